sa_skew_enable_gen: RTL and testbench
=====================================

# sa_skew_enable_gen

Parametrised enable sequencer for the systolic array's column (or row) feed lanes. It generalises the single-pass one-hot column strobe into a start/done-handshaked sequencer with two modes: a rotating one-hot strobe, and a skewed wavefront where lane j is enabled for LEN beats starting j cycles after lane 0. It sits between the array controller and the operand feeders, and gates which lanes consume data each cycle. It supports stall and reports progress.

## Interface
- COL, default 3: number of lanes, ≥1; o_data bit j = lane j (LSB = lane 0).
- LEN, default 4: beats per lane per job, ≥1.
- CW (localparam): $clog2(COL*LEN+1), the width of the run counter.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  job request; sampled only in IDLE.
- i_mode  in  1  0 = rotate, 1 = wavefront; latched on an accepted start.
- i_stall  in  1  freezes sequencing; acts combinationally on o_data.
- o_data  out  COL  per-lane enable.
- o_busy  out  1  high in RUN and DONE.
- o_done  out  1  one-cycle pulse at job end.
- o_cycle  out  CW  current run counter t.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - o_data=0; t=0.
  - i_start=1 → RUN; latch i_mode; t←0; lane counter←0.
- RUN:
  - TOTAL = COL*LEN in rotate mode and COL+LEN-1 in wavefront mode.
  - Non-stalled edge: t←t+1. In rotate mode the lane counter also advances, wrapping COL-1→0.
  - Non-stalled edge with t==TOTAL-1 → DONE.
  - Stalled edge: t and lane counter hold; the state holds.
- DONE: o_done=1, o_data=0; next edge → IDLE unconditionally.
- o_data (combinational from registered state, t, lane counter and live i_stall):
  - 0 unless state==RUN and i_stall==0.
  - Rotate: exactly bit[lane counter] set.
  - Wavefront: bit j set iff j ≤ t and t−j < LEN.
- The lane counter is a separate register; there are no modulo or divide operators.
- The wavefront compare is per lane, using CW-bit unsigned arithmetic, with j compared before subtraction so the difference never underflows.
- i_start outside IDLE is ignored.
- i_mode changes outside an accepted start are ignored.
- A start in the same cycle as DONE is ignored; it is accepted only once the block is back in IDLE.
- COL=1 is legal: the rotate pattern is the constant 1 for LEN cycles, and no index-minus-one logic is used.
- i_rst asserted at any time, including mid-RUN: state=IDLE, t=0, lane counter=0, latched mode=0, and all outputs 0 immediately, without waiting for a clock edge. Sequencing resumes only on a fresh i_start after i_rst deasserts.

## Timing
- Start latency: i_start high at edge N → o_busy=1 and o_data=pattern(0) during cycle N+1, absent stall.
- Each non-stalled RUN cycle presents exactly one pattern step; the job spans exactly TOTAL non-stalled RUN cycles.
- o_done is high in the single cycle after the last pattern; o_busy falls one cycle after that.
- Back-to-back jobs: minimum start-to-start spacing is TOTAL+2 cycles.
- i_stall affects o_data in the same cycle (zero latency) and affects t at the next edge.
- A stall held during the final pattern cycle delays DONE until the stall is released.
- i_stall in IDLE or DONE has no effect.

## Test plan
All scenarios use COL=3, LEN=4 unless stated.
- Rotate: i_mode=0, start pulse → o_data 001,010,100 repeated 4×, 12 cycles, o_cycle 0..11; then o_done=1 with o_data=000 for one cycle; o_busy then 0.
- Wavefront: i_mode=1, start → o_data 001,011,111,111,110,100 (6 cycles); then o_done pulse.
- Stall: wavefront job with i_stall=1 for 2 cycles while o_cycle=2 → o_data=000 on those cycles and o_cycle holds at 2; then 111,111,110,100; o_done arrives 8 cycles after the first pattern.
- Ignored inputs: mid-run i_start=1 with i_mode flipped → pattern is unchanged and still has the original length. A start in the DONE cycle is ignored; a start in the following IDLE cycle begins a new job.
- Reset: assert i_rst at rotate t=5 → o_data=000, o_busy=0, o_cycle=0 with no clock edge needed. After release, no activity occurs until the next i_start.
- Degenerate (COL=1, LEN=1): either mode, start → o_data=1 for exactly one cycle, then o_done pulse.

Source files
------------

// File: rtl/sa_skew_enable_gen.sv
// Enable sequencer for the systolic array feed lanes.
// Produces either a rotating one-hot lane strobe or a skewed wavefront in
// which lane j is enabled for LEN beats starting j cycles after lane 0.
// Jobs are start/done handshaked, can be stalled, and report progress.
module sa_skew_enable_gen #(
    parameter int COL = 3,
    parameter int LEN = 4,
    localparam int CW = $clog2(COL*LEN+1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic           i_mode,
    input  logic           i_stall,
    output logic [COL-1:0] o_data,
    output logic           o_busy,
    output logic           o_done,
    output logic [CW-1:0]  o_cycle
);

    // The lane counter needs at least one bit even for a single lane.
    localparam int LW = (COL > 1) ? $clog2(COL) : 1;

    localparam logic [CW-1:0] LAST_ROT = CW'(COL*LEN-1);
    localparam logic [CW-1:0] LAST_WAV = CW'(COL+LEN-2);
    localparam logic [CW-1:0] LEN_CW   = CW'(LEN);
    localparam logic [LW-1:0] LANE_MAX = LW'(COL-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   t, t_nxt;
    logic [LW-1:0]   lane, lane_nxt;
    logic            mode, mode_nxt;
    logic [CW-1:0]   last_t;

    // The final run-counter value depends on the mode latched for this job.
    assign last_t = mode ? LAST_WAV : LAST_ROT;

    // State, run counter, lane counter and latched mode. Reset is asynchronous
    // so every output returns to zero the moment reset is raised.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            t     <= '0;
            lane  <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
            lane  <= lane_nxt;
            mode  <= mode_nxt;
        end
    end

    // Next-state logic. A start is honoured only in IDLE; a stall freezes
    // everything in RUN; DONE lasts exactly one cycle. The lane counter wraps
    // by comparison so no modulo hardware is needed.
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        lane_nxt  = lane;
        mode_nxt  = mode;
        case (state)
            IDLE: begin
                t_nxt    = '0;
                lane_nxt = '0;
                if (i_start) begin
                    state_nxt = RUN;
                    mode_nxt  = i_mode;
                end
            end
            RUN: begin
                if (!i_stall) begin
                    t_nxt = t + 1'b1;
                    if (!mode) begin
                        lane_nxt = (lane == LANE_MAX) ? '0 : lane + 1'b1;
                    end
                    if (t == last_t) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                t_nxt     = '0;
                lane_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
                t_nxt     = '0;
                lane_nxt  = '0;
            end
        endcase
    end

    // Lane enables. Only driven while running and not stalled, so a stall
    // gates consumption in the same cycle. The wavefront test checks j <= t
    // before subtracting so the difference can never wrap.
    always_comb begin
        o_data = '0;
        if (state == RUN && !i_stall) begin
            for (int j = 0; j < COL; j++) begin
                if (!mode) begin
                    o_data[j] = (lane == LW'(j));
                end else begin
                    o_data[j] = (CW'(j) <= t) && ((t - CW'(j)) < LEN_CW);
                end
            end
        end
    end

    // Status outputs follow the registered state directly.
    assign o_busy  = (state == RUN) || (state == DONE);
    assign o_done  = (state == DONE);
    assign o_cycle = t;

endmodule

// File: tb/tb_sa_skew_enable_gen.sv
// Self-checking bench for sa_skew_enable_gen: a 3x4 instance driven by
// randomized and directed jobs, plus a 1x1 instance for the degenerate case.
module tb_sa_skew_enable_gen;

    localparam int COL = 3;
    localparam int LEN = 4;
    localparam int CW  = $clog2(COL*LEN+1);
    localparam int VW  = 2 + CW + COL;

    logic           clk;
    logic           rst;
    logic           start;
    logic           mode;
    logic           stall;
    logic [COL-1:0] data;
    logic           busy;
    logic           done;
    logic [CW-1:0]  cyc;

    logic           d1_start;
    logic           d1_mode;
    logic           d1_stall;
    logic [0:0]     d1_data;
    logic           d1_busy;
    logic           d1_done;
    logic [0:0]     d1_cyc;

    int n_checks = 0;
    int n_fail   = 0;

    sa_skew_enable_gen #(.COL(COL), .LEN(LEN)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_mode  (mode),
        .i_stall (stall),
        .o_data  (data),
        .o_busy  (busy),
        .o_done  (done),
        .o_cycle (cyc)
    );

    sa_skew_enable_gen #(.COL(1), .LEN(1)) dut1 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (d1_start),
        .i_mode  (d1_mode),
        .i_stall (d1_stall),
        .o_data  (d1_data),
        .o_busy  (d1_busy),
        .o_done  (d1_done),
        .o_cycle (d1_cyc)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected lane pattern for step s of a job, straight from the lane rules:
    // rotate enables lane s mod COL; wavefront enables lane j when 0 <= s-j < LEN.
    function automatic logic [COL-1:0] pat(input bit m, input int s);
        logic [COL-1:0] p;
        p = '0;
        for (int j = 0; j < COL; j++) begin
            if (!m) p[j] = (j == (s % COL));
            else    p[j] = ((s - j) >= 0) && ((s - j) < LEN);
        end
        return p;
    endfunction

    // One complete job on the 3x4 instance. Expectations are built from the
    // job step count, not from any knowledge of the design's registers.
    task automatic run_job(input bit m, input int stall_pct, input int st_step,
                           input int st_cnt, input bit noise, input bit prestarted,
                           input bit chain, input bit next_mode, output int run_cycles);
        int total;
        int step;
        int stalls;
        int guard;
        bit stl;
        logic [VW-1:0] exp_v;
        logic [VW-1:0] got_v;
        logic [2+COL-1:0] exp_s;
        logic [2+COL-1:0] got_s;
        total = m ? (COL + LEN - 1) : (COL * LEN);
        run_cycles = 0;
        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1;
            mode  = m;
            stall = 1'($urandom_range(1));
            #1;
            got_v = {busy, done, cyc, data};
            exp_v = '0;
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL idle_before_start got=%h want=%h", got_v, exp_v);
            end
        end
        step = 0;
        stalls = 0;
        guard = 0;
        while (step < total && guard < 200) begin
            @(negedge clk);
            start = noise ? 1'($urandom_range(1)) : 1'b0;
            mode  = noise ? ~m : 1'($urandom_range(1));
            stl = ((step == st_step) && (stalls < st_cnt)) ||
                  (int'($urandom_range(99)) < stall_pct);
            if (stl && step == st_step) stalls++;
            stall = stl;
            #1;
            got_v = {busy, done, cyc, data};
            exp_v = {1'b1, 1'b0, CW'(step), (stl ? {COL{1'b0}} : pat(m, step))};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL run_step mode=%0d step=%0d stall=%0d got=%h want=%h",
                         m, step, stl, got_v, exp_v);
            end
            run_cycles++;
            guard++;
            if (!stl) step++;
        end
        if (step < total) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL run_timeout reached step=%0d want=%0d", step, total);
        end
        @(negedge clk);
        start = noise;
        mode  = 1'($urandom_range(1));
        stall = 1'($urandom_range(1));
        #1;
        got_s = {busy, done, data};
        exp_s = {1'b1, 1'b1, {COL{1'b0}}};
        n_checks++;
        if (got_s !== exp_s) begin
            n_fail++;
            $display("[TB] FAIL done_cycle got=%h want=%h", got_s, exp_s);
        end
        @(negedge clk);
        start = chain;
        mode  = next_mode;
        stall = 1'($urandom_range(1));
        #1;
        got_v = {busy, done, cyc, data};
        exp_v = '0;
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL idle_after_done got=%h want=%h", got_v, exp_v);
        end
    endtask

    // Outputs must be zero while reset is held.
    task automatic test_reset();
        logic [VW-1:0] got_v;
        logic [3:0] got1;
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; stall = 1'b0;
        d1_start = 1'b0; d1_mode = 1'b0; d1_stall = 1'b0;
        #1;
        got_v = {busy, done, cyc, data};
        n_checks++;
        if (got_v !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_main got=%h want=0", got_v);
        end
        got1 = {d1_busy, d1_done, d1_cyc, d1_data};
        n_checks++;
        if (got1 !== 4'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_deg got=%h want=0", got1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Plain rotate job: twelve one-hot steps.
    task automatic test_rotate();
        int rc;
        run_job(1'b0, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, rc);
        n_checks++;
        if (rc !== COL * LEN) begin
            n_fail++;
            $display("[TB] FAIL rotate_len got=%0d want=%0d", rc, COL * LEN);
        end
    endtask

    // Plain wavefront job: six steps.
    task automatic test_wavefront();
        int rc;
        run_job(1'b1, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, rc);
        n_checks++;
        if (rc !== COL + LEN - 1) begin
            n_fail++;
            $display("[TB] FAIL wave_len got=%0d want=%0d", rc, COL + LEN - 1);
        end
    endtask

    // Wavefront with a two-cycle stall at step 2: done arrives eight cycles in.
    task automatic test_stall();
        int rc;
        run_job(1'b1, 0, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, rc);
        n_checks++;
        if (rc !== 8) begin
            n_fail++;
            $display("[TB] FAIL stall_len got=%0d want=8", rc);
        end
        run_job(1'b1, 0, COL + LEN - 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, rc);
        n_checks++;
        if (rc !== COL + LEN + 2) begin
            n_fail++;
            $display("[TB] FAIL stall_last_len got=%0d want=%0d", rc, COL + LEN + 2);
        end
    endtask

    // Start and mode toggled mid-run and start raised in DONE must be ignored.
    task automatic test_ignored_inputs();
        int rc;
        run_job(1'b0, 0, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0, rc);
        run_job(1'b1, 0, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0, rc);
    endtask

    // A start in the first IDLE cycle after DONE begins the next job at once.
    task automatic test_back_to_back();
        int rc;
        run_job(1'b0, 0, -1, 0, 1'b0, 1'b0, 1'b1, 1'b1, rc);
        run_job(1'b1, 0, -1, 0, 1'b0, 1'b1, 1'b1, 1'b0, rc);
        run_job(1'b0, 0, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, rc);
    endtask

    // Asynchronous reset in the middle of a rotate job.
    task automatic test_reset_midrun();
        logic [VW-1:0] got_v;
        logic [VW-1:0] exp_v;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; stall = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
        end
        got_v = {busy, done, cyc, data};
        exp_v = {1'b1, 1'b0, CW'(5), pat(1'b0, 5)};
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_step got=%h want=%h", got_v, exp_v);
        end
        #1;
        rst = 1'b1;
        #1;
        got_v = {busy, done, cyc, data};
        n_checks++;
        if (got_v !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_reset got=%h want=0", got_v);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'($urandom_range(1));
            mode  = 1'($urandom_range(1));
            #1;
            got_v = {busy, done, cyc, data};
            n_checks++;
            if (got_v !== '0) begin
                n_fail++;
                $display("[TB] FAIL post_reset_idle i=%0d got=%h want=0", i, got_v);
            end
        end
    endtask

    // Randomized jobs with random stalls, noise and chaining.
    task automatic test_random();
        int rc;
        bit chain;
        bit prev_chain;
        bit m;
        bit nm;
        prev_chain = 1'b0;
        nm = 1'b0;
        for (int k = 0; k < 12; k++) begin
            m = prev_chain ? nm : 1'($urandom_range(1));
            chain = (k < 11) ? 1'($urandom_range(1)) : 1'b0;
            nm = 1'($urandom_range(1));
            run_job(m, 25, -1, 0, 1'($urandom_range(1)), prev_chain, chain, nm, rc);
            prev_chain = chain;
        end
        start = 1'b0;
    endtask

    // COL=1, LEN=1 instance: one enabled cycle then DONE, in both modes.
    task automatic test_degenerate();
        logic [3:0] got;
        logic [3:0] exp_v;
        for (int mi = 0; mi < 2; mi++) begin
            @(negedge clk);
            d1_start = 1'b1;
            d1_mode  = 1'(mi);
            #1;
            got = {d1_busy, d1_done, d1_cyc, d1_data};
            n_checks++;
            if (got !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL deg_idle mode=%0d got=%b want=0000", mi, got);
            end
            @(negedge clk);
            d1_start = 1'b0;
            d1_mode  = ~1'(mi);
            #1;
            got = {d1_busy, d1_done, d1_cyc, d1_data};
            exp_v = 4'b1001;
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL deg_run mode=%0d got=%b want=%b", mi, got, exp_v);
            end
            @(negedge clk);
            #1;
            got = {d1_busy, d1_done, 1'b0, d1_data};
            exp_v = 4'b1100;
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL deg_done mode=%0d got=%b want=%b", mi, got, exp_v);
            end
            @(negedge clk);
            #1;
            got = {d1_busy, d1_done, d1_cyc, d1_data};
            n_checks++;
            if (got !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL deg_after mode=%0d got=%b want=0000", mi, got);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_rotate();
        test_wavefront();
        test_stall();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_midrun();
        test_degenerate();
        test_random();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
